// File: rtl/sprite_rom_burst_reader_if.sv
// rtl/sprite_rom_burst_reader_if.sv - request and pixel-output bundle for sprite_rom_burst_reader
interface sprite_rom_burst_reader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_rom_id;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_transp;

    modport master (
        output req_valid, req_rom_id, req_addr, req_len,
        input  req_ready, out_valid, out_data, out_last, out_transp
    );

    modport slave (
        input  req_valid, req_rom_id, req_addr, req_len,
        output req_ready, out_valid, out_data, out_last, out_transp
    );
endinterface

// File: rtl/sprite_rom_burst_reader.sv
// rtl/sprite_rom_burst_reader.sv - burst ROM read engine with registered output mux; TRANSPARENCY_EN adds colour-key flag
module sprite_rom_burst_reader #(
    parameter int NUM_ROMS = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 12,
    parameter int ROM_LAT  = 1,
    parameter logic [DATA_W-1:0] TRANS_COL = 16'hF81F
) (
    input  logic                       clock,
    input  logic                       reset,
    sprite_rom_burst_reader_if.slave   io,
    output logic [ADDR_W-1:0]          rom_addr,
    input  logic [NUM_ROMS*DATA_W-1:0] rom_q_bus,
    output logic                       err_bad_id
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [LEN_W-1:0]    remaining;
    logic [3:0]          rom_id_q;
    logic [ROM_LAT-1:0]  pipe_valid, pipe_last;
    logic                out_valid_q, out_last_q, out_transp_q;
    logic [DATA_W-1:0]   out_data_q, rom_word;
    logic                accept, issuing, issue_last;

    assign accept     = io.req_valid && (state == IDLE);
    assign issuing    = (state == ISSUE);
    assign issue_last = (remaining == LEN_W'(1));

    assign io.req_ready  = (state == IDLE);
    assign io.out_valid  = out_valid_q;
    assign io.out_data   = out_data_q;
    assign io.out_last   = out_last_q;
    assign io.out_transp = out_transp_q;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (io.req_len != '0)) state_nxt = ISSUE;
            ISSUE:   if (issue_last) state_nxt = DRAIN;
            DRAIN:   if (out_last_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Out-of-range ids match no slot and so read back as zero.
    always_comb begin
        rom_word = '0;
        for (int k = 0; k < NUM_ROMS; k++) begin
            if (rom_id_q == 4'(k)) rom_word = rom_q_bus[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rom_addr    <= '0;
            remaining   <= '0;
            rom_id_q    <= '0;
            err_bad_id  <= 1'b0;
            pipe_valid  <= '0;
            pipe_last   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (accept) begin
                rom_id_q <= io.req_rom_id;
                if ({1'b0, io.req_rom_id} >= 5'(NUM_ROMS)) err_bad_id <= 1'b1;
                if (io.req_len != '0) begin
                    rom_addr  <= io.req_addr;
                    remaining <= io.req_len;
                end
            end else if (issuing && !issue_last) begin
                rom_addr  <= rom_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end

            // {valid,last} travel alongside the address through the ROM latency.
            pipe_valid[0] <= issuing;
            pipe_last[0]  <= issuing && issue_last;
            for (int k = 1; k < ROM_LAT; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_last[k]  <= pipe_last[k-1];
            end

            out_valid_q <= pipe_valid[ROM_LAT-1];
            out_last_q  <= pipe_last[ROM_LAT-1];
            out_data_q  <= pipe_valid[ROM_LAT-1] ? rom_word : '0;
        end
    end

`ifdef TRANSPARENCY_EN
    always_ff @(posedge clock) begin
        if (reset) out_transp_q <= 1'b0;
        else       out_transp_q <= pipe_valid[ROM_LAT-1] && (rom_word == TRANS_COL);
    end
`else
    logic unused_trans_col;
    assign unused_trans_col = ^TRANS_COL;
    assign out_transp_q     = 1'b0;
`endif
endmodule

// File: tb/tb_sprite_rom_burst_reader.sv
// tb/tb_sprite_rom_burst_reader.sv - self-checking bench for sprite_rom_burst_reader
module tb_sprite_rom_burst_reader;
    localparam int NUM_ROMS = 4;
    localparam int ROM_LAT  = 1;
`ifdef TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    typedef struct {
        int unsigned cyc;
        logic [15:0] data;
        bit          last;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [15:0] rom_addr;
    logic [NUM_ROMS*16-1:0] rom_q_bus;
    logic err_bad_id;
    logic [15:0] apipe [ROM_LAT];

    sprite_rom_burst_reader_if #(.ADDR_W(16), .DATA_W(16), .LEN_W(12)) io ();

    sprite_rom_burst_reader #(
        .NUM_ROMS(NUM_ROMS), .ADDR_W(16), .DATA_W(16), .LEN_W(12), .ROM_LAT(ROM_LAT),
        .TRANS_COL(16'hF81F)
    ) dut (
        .clock(clock), .reset(reset), .io(io),
        .rom_addr(rom_addr), .rom_q_bus(rom_q_bus), .err_bad_id(err_bad_id)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    int unsigned n_total = 0;
    int unsigned n_pass = 0;
    bit chk_en = 1'b0;

    exp_t q[$];
    bit          have_burst;
    int unsigned b_t0, b_len, err_from;
    logic [15:0] b_addr, hold_addr;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] rom_word(input int k, input logic [15:0] a);
        if (a[3:0] == 4'd5) return 16'hF81F;
        return {k[1:0], a[13:0]};
    endfunction

    // External ROMs: registered address pipeline of depth ROM_LAT.
    always @(posedge clock) begin
        apipe[0] <= rom_addr;
        for (int k = 1; k < ROM_LAT; k++) apipe[k] <= apipe[k-1];
    end
    always_comb begin
        rom_q_bus = '0;
        for (int k = 0; k < NUM_ROMS; k++) rom_q_bus[k*16 +: 16] = rom_word(k, apipe[ROM_LAT-1]);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    function automatic bit model_ready(input int unsigned c);
        return !(have_burst && c > b_t0 && c <= b_t0 + ROM_LAT + 1 + b_len);
    endfunction

    function automatic logic [15:0] model_addr(input int unsigned c);
        if (!have_burst || c <= b_t0) return hold_addr;
        if (c - b_t0 - 1 >= b_len) return b_addr + 16'(b_len - 1);
        return b_addr + 16'(c - b_t0 - 1);
    endfunction

    task automatic model_clear();
        q.delete();
        have_burst = 1'b0;
        hold_addr  = '0;
        err_from   = 32'hFFFF_FFFF;
    endtask

    task automatic model_accept(input int unsigned c, input int id, input logic [15:0] a, input int unsigned l);
        exp_t e;
        if (id >= NUM_ROMS && err_from > c + 1) err_from = c + 1;
        if (l == 0) return;
        if (have_burst) hold_addr = b_addr + 16'(b_len - 1);
        have_burst = 1'b1;
        b_t0 = c; b_addr = a; b_len = l;
        for (int unsigned i = 0; i < l; i++) begin
            e.cyc  = c + ROM_LAT + 2 + i;
            e.data = (id < NUM_ROMS) ? rom_word(id, a + 16'(i)) : 16'h0000;
            e.last = (i == l - 1);
            q.push_back(e);
        end
    endtask

    task automatic step(input bit v, input int id, input logic [15:0] a, input int unsigned l);
        io.req_valid  = v;
        io.req_rom_id = 4'(id);
        io.req_addr   = a;
        io.req_len    = 12'(l);
        if (v && model_ready(cyc)) model_accept(cyc, id, a, l);
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 16'h0, 0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        io.req_valid = 1'b0;
        @(posedge clock); #1;
        model_clear();
        repeat (n - 1) begin @(posedge clock); #1; end
        reset = 1'b0;
    endtask

    exp_t e_cur;
    bit   ev;
    always @(negedge clock) begin
        if (chk_en) begin
            ev = (q.size() > 0) && (q[0].cyc == cyc);
            if (ev) e_cur = q.pop_front();
            chk("out_valid", io.out_valid, ev);
            if (ev) begin
                chk("out_data", io.out_data, e_cur.data);
                chk("out_last", io.out_last, e_cur.last);
                chk("out_transp", io.out_transp, TRANSP_EN && (e_cur.data == 16'hF81F));
            end
            chk("req_ready", io.req_ready, model_ready(cyc));
            chk("rom_addr", rom_addr, model_addr(cyc));
            chk("err_bad_id", err_bad_id, cyc >= err_from);
        end
    end

    initial begin
        io.req_valid = 1'b0; io.req_rom_id = '0; io.req_addr = '0; io.req_len = '0;
        model_clear();
        do_reset(3);
        chk_en = 1'b1;
        chk("rst_ready", io.req_ready, 1'b1);
        chk("rst_valid", io.out_valid, 1'b0);
        chk("rst_addr", rom_addr, 16'h0000);
        idle(2);

        // Basic burst from ROM 2.
        step(1'b1, 2, 16'h0010, 4);
        chk("t1_addr0", rom_addr, 16'h0010);
        idle(2);
        chk("t1_first_valid", io.out_valid, 1'b1);
        chk("t1_first_data", io.out_data, 16'h8010);
        chk("t1_busy", io.req_ready, 1'b0);
        idle(3);
        chk("t1_last", io.out_last, 1'b1);
        chk("t1_last_data", io.out_data, 16'h8013);
        idle(1);
        chk("t1_ready_back", io.req_ready, 1'b1);
        chk("t1_no_valid", io.out_valid, 1'b0);

        // Address wrap.
        step(1'b1, 1, 16'hFFFE, 4);
        chk("t2_addr0", rom_addr, 16'hFFFE);
        idle(2);
        chk("t2_addr_wrap", rom_addr, 16'h0000);
        chk("t2_data0", io.out_data, 16'h7FFE);
        idle(2);
        chk("t2_data2", io.out_data, 16'h4000);
        idle(3);

        // Bad ROM id, sticky error.
        step(1'b1, 7, 16'h0020, 2);
        chk("t3_err_set", err_bad_id, 1'b1);
        idle(2);
        chk("t3_zero_data", io.out_data, 16'h0000);
        idle(3);
        step(1'b1, 0, 16'h0005, 1);
        idle(5);
        chk("t3_err_sticky", err_bad_id, 1'b1);

        // Reset in the middle of an 8-word burst.
        do_reset(2);
        chk("t4_err_clear", err_bad_id, 1'b0);
        step(1'b1, 0, 16'h0100, 8);
        idle(4);
        chk("t4_word2", io.out_data, 16'h0102);
        reset = 1'b1;
        @(posedge clock); #1;
        model_clear();
        chk("t4_rst_valid", io.out_valid, 1'b0);
        chk("t4_rst_ready", io.req_ready, 1'b1);
        chk("t4_rst_last", io.out_last, 1'b0);
        reset = 1'b0;
        step(1'b1, 3, 16'h0FFF, 3);
        idle(7);

        // Zero length, then a request held through a burst.
        step(1'b1, 1, 16'h0040, 0);
        chk("t5_len0_ready", io.req_ready, 1'b1);
        idle(3);
        step(1'b1, 2, 16'h0050, 3);
        repeat (4) step(1'b1, 3, 16'h0060, 5);
        idle(6);

        // Colour key word inside a burst.
        step(1'b1, 0, 16'h0003, 4);
        idle(4);
        chk("t6_key_data", io.out_data, 16'hF81F);
        chk("t6_key_transp", io.out_transp, TRANSP_EN);
        idle(3);

        // Randomized traffic.
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset($urandom_range(1, 3));
            end else if (io.req_valid && !model_ready(cyc) && $urandom_range(0, 3) != 0) begin
                step(1'b1, io.req_rom_id, io.req_addr, io.req_len);
            end else begin
                step($urandom_range(0, 2) != 0,
                     ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3),
                     ($urandom_range(0, 4) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom),
                     $urandom_range(0, 20));
            end
        end
        idle(40);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
